// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } DIV_STATE;

endpackage

// File: rtl/seq_divider_restore_step.sv
// One restoring-division step: shift in the next dividend bit and trial-subtract
// the divisor magnitude on a carry-lookahead adder.
module claa #(
    parameter int width        = 9,
    parameter int cascade_size = 4
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             c_in,
    output logic [width-1:0] sum,
    output logic             c_out
);

    localparam int blocks = (width + cascade_size - 1) / cascade_size;

    logic [width-1:0] g;
    logic [width-1:0] p;
    logic [width:0]   c;
    logic             grp_g;
    logic             grp_p;
    logic             blk_cin;

    assign g = a & b;
    assign p = a ^ b;

    // Ripple inside each block, group generate/propagate skips between blocks.
    always_comb begin
        c       = '0;
        c[0]    = c_in;
        grp_g   = 1'b0;
        grp_p   = 1'b1;
        blk_cin = 1'b0;
        for (int unsigned blk = 0; blk < blocks; blk++) begin
            int unsigned lo;
            int unsigned hi;
            lo      = blk * cascade_size;
            hi      = (lo + cascade_size > width) ? width : lo + cascade_size;
            blk_cin = c[lo];
            grp_g   = 1'b0;
            grp_p   = 1'b1;
            for (int unsigned k = lo; k < hi; k++) begin
                c[k+1] = g[k] | (p[k] & c[k]);
                grp_g  = g[k] | (p[k] & grp_g);
                grp_p  = grp_p & p[k];
            end
            c[hi] = grp_g | (grp_p & blk_cin);
        end
    end

    assign sum   = p ^ c[width-1:0];
    assign c_out = c[width];

endmodule

module div_restore_step #(
    parameter int word_width   = 8,
    parameter int cascade_size = 4
) (
    input  logic [word_width-1:0] partial_rem,
    input  logic                  next_bit,
    input  logic [word_width-1:0] divisor_mag,
    output logic [word_width-1:0] new_rem,
    output logic                  q_bit
);

    logic [word_width:0] shifted;
    logic [word_width:0] diff;
    logic                diff_msb_unused;

    assign shifted = {partial_rem, next_bit};

    claa #(
        .width        (word_width + 1),
        .cascade_size (cascade_size)
    ) u_claa (
        .a     (shifted),
        .b     (~{1'b0, divisor_mag}),
        .c_in  (1'b1),
        .sum   (diff),
        .c_out (q_bit)
    );

    // Either result fits in word_width bits, so the top sum bit is always zero when kept.
    assign diff_msb_unused = diff[word_width];
    assign new_rem         = q_bit ? diff[word_width-1:0] : shifted[word_width-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, signed via magnitude
// division plus a final sign fixup, valid/ready on both sides.
module seq_divider
    import div_pkg::*;
#(
    parameter int word_width   = 8,
    parameter int cascade_size = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  is_signed,
    input  logic [word_width-1:0] dividend,
    input  logic [word_width-1:0] divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [word_width-1:0] quotient,
    output logic [word_width-1:0] remainder,
    output logic                  div_by_zero
);

    localparam int cw = $clog2(word_width) + 1;

    DIV_STATE              state;
    DIV_STATE              next_state;
    logic [word_width-1:0] dvd_reg;
    logic [word_width-1:0] rem_reg;
    logic [word_width-1:0] dsr_mag;
    logic [cw-1:0]         count;
    logic                  sgn;
    logic                  dvd_neg;
    logic                  dsr_neg;
    logic                  zero_div;
    logic [word_width-1:0] new_rem;
    logic                  q_bit;

    div_restore_step #(
        .word_width   (word_width),
        .cascade_size (cascade_size)
    ) u_step (
        .partial_rem (rem_reg),
        .next_bit    (dvd_reg[word_width-1]),
        .divisor_mag (dsr_mag),
        .new_rem     (new_rem),
        .q_bit       (q_bit)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = (divisor == '0) ? FIXUP : BUSY;
            BUSY:    if (count == cw'(word_width - 1)) next_state = FIXUP;
            FIXUP:   next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            dvd_reg     <= '0;
            rem_reg     <= '0;
            dsr_mag     <= '0;
            count       <= '0;
            sgn         <= 1'b0;
            dvd_neg     <= 1'b0;
            dsr_neg     <= 1'b0;
            zero_div    <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (in_valid) begin
                    sgn      <= is_signed;
                    dvd_neg  <= is_signed & dividend[word_width-1];
                    dsr_neg  <= is_signed & divisor[word_width-1];
                    dvd_reg  <= (is_signed & dividend[word_width-1]) ? -dividend : dividend;
                    dsr_mag  <= (is_signed & divisor[word_width-1]) ? -divisor : divisor;
                    zero_div <= (divisor == '0);
                    rem_reg  <= '0;
                    count    <= '0;
                end
                BUSY: begin
                    rem_reg <= new_rem;
                    dvd_reg <= {dvd_reg[word_width-2:0], q_bit};
                    count   <= count + 1'b1;
                end
                FIXUP: begin
                    // Divide-by-zero re-negates the latched magnitude to recover the raw dividend.
                    if (zero_div) begin
                        quotient    <= '1;
                        remainder   <= dvd_neg ? -dvd_reg : dvd_reg;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= (sgn & (dvd_neg ^ dsr_neg)) ? -dvd_reg : dvd_reg;
                        remainder   <= dvd_neg ? -rem_reg : rem_reg;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
